serial_add2_ctrl: RTL and testbench

Sequential operand sequencer for the 2-bit adder slice. It accepts two WIDTH-bit operands, feeds them to the slice two bits per cycle (LSB pair first), and carries the slice's cout into the next cycle's cin. It collects each slice sum into a WIDTH-bit result and signals completion with a one-cycle done pulse. It sits directly upstream of the slice, driving A/B/cin, and directly downstream of it, consuming sum/cout.

---
 rtl/serial_add2_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_add2_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add2_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add2_ctrl
// Brief    : Sequencer driving a 2-bit adder slice over WIDTH/2 cycles, LSB
//            pair first. Optional macro SERIAL_SUB_EN adds a subtract mode.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add2_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  output logic             slice_cin,
  input  logic [1:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int STEPS = WIDTH / 2;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_carry_out;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W:0]   w_bit;
  logic [WIDTH-1:0] w_b_in;
  logic             w_cin_in;

  // LSB position of the bit pair handled this cycle
  assign w_bit = {r_idx, 1'b0};

`ifdef SERIAL_SUB_EN
  // Subtraction as a + ~b + 1; carry_out then reads as "no borrow"
  assign w_b_in   = sub ? ~op_b : op_b;
  assign w_cin_in = sub ? 1'b1  : cin_init;
`else
  assign w_b_in   = op_b;
  assign w_cin_in = cin_init;
`endif

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    slice_a   = 2'b00;
    slice_b   = 2'b00;
    slice_cin = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        busy      = 1'b1;
        slice_a   = r_a[w_bit +: 2];
        slice_b   = r_b[w_bit +: 2];
        slice_cin = r_carry;
        if (r_idx == C_LAST_IDX) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_carry_out <= 1'b0;
      r_idx       <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= w_b_in;
            r_carry <= w_cin_in;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_result[w_bit +: 2] <= slice_sum;
          r_carry              <= slice_cout;
          r_idx                <= r_idx + IDX_W'(1);
          if (r_idx == C_LAST_IDX) r_carry_out <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;

endmodule
`default_nettype wire

// File: tb/tb_serial_add2_ctrl.sv
`default_nettype none
// Bench for serial_add2_ctrl: behavioural 2-bit slice, arithmetic reference
// model, per-cycle compare, directed cases and randomized traffic.
module tb_serial_add2_ctrl;

  localparam int WIDTH = 8;
  localparam int STEPS = WIDTH / 2;
`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             cin_init = 1'b0;
  logic             sub = 1'b0;
  logic             busy, done, carry_out, slice_cin, slice_cout;
  logic [WIDTH-1:0] result;
  logic [1:0]       slice_a, slice_b, slice_sum;

  int checks = 0;
  int errors = 0;

  serial_add2_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .cin_init(cin_init),
`ifdef SERIAL_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;

  // The 2-bit adder slice the sequencer drives
  always_comb {slice_cout, slice_sum} = 3'(slice_a) + 3'(slice_b) + 3'(slice_cin);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: m_cnt counts cycles since acceptance; 1..STEPS run, STEPS+1 done
  int               m_cnt;
  int unsigned      m_a, m_b, m_cin;
  logic [WIDTH-1:0] m_res;
  logic             m_co;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_a   <= 0;
      m_b   <= 0;
      m_cin <= 0;
      m_res <= '0;
      m_co  <= 1'b0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_a   <= 32'(op_a);
        m_b   <= (SUB_EN && sub) ? ((32'd1 << WIDTH) - 32'd1) - 32'(op_b) : 32'(op_b);
        m_cin <= (SUB_EN && sub) ? 32'd1 : 32'(cin_init);
        m_cnt <= 1;
      end
    end else if (m_cnt == STEPS) begin
      m_res <= WIDTH'(m_a + m_b + m_cin);
      m_co  <= ((m_a + m_b + m_cin) >> WIDTH) != 0;
      m_cnt <= STEPS + 1;
    end else if (m_cnt == STEPS + 1) begin
      m_cnt <= 0;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    int k;
    int unsigned ea, eb, ec, mask;
    if (!rst) begin
      ea = 0; eb = 0; ec = 0;
      if (m_cnt >= 1 && m_cnt <= STEPS) begin
        k    = m_cnt - 1;
        mask = (32'd1 << (2 * k)) - 32'd1;
        ea   = (m_a >> (2 * k)) & 32'd3;
        eb   = (m_b >> (2 * k)) & 32'd3;
        ec   = (((m_a & mask) + (m_b & mask) + m_cin) >> (2 * k)) & 32'd1;
      end
      chk("busy", 32'(busy), 32'(m_cnt != 0));
      chk("done", 32'(done), 32'(m_cnt == STEPS + 1));
      chk("slice_a", 32'(slice_a), ea);
      chk("slice_b", 32'(slice_b), eb);
      chk("slice_cin", 32'(slice_cin), ec);
      if (m_cnt == 0 || m_cnt == STEPS + 1) begin
        chk("result", 32'(result), 32'(m_res));
        chk("carry_out", 32'(carry_out), 32'(m_co));
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic s, input logic [7:0] exp_res, input logic exp_co,
                        input logic [3:0] exp_cins, input bit chk_cins, input bit glitch);
    int cyc = 0;
    int nbusy = 0;
    bit seen = 1'b0;
    logic [3:0] cins = '0;
    @(posedge clk); #1;
    op_a = a; op_b = b; cin_init = ci; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) nbusy++;
      if (cyc <= STEPS) cins[cyc-1] = slice_cin;
      if (glitch && cyc == 2) begin start = 1'b1; op_a = 8'hFF; end
      if (glitch && cyc == 3) start = 1'b0;
      if (done) seen = 1'b1;
    end
    chk("done_latency", 32'(cyc), 32'(STEPS + 1));
    chk("op_result", 32'(result), 32'(exp_res));
    chk("op_carry", 32'(carry_out), 32'(exp_co));
    chk("model_result", 32'(m_res), 32'(exp_res));
    if (chk_cins) chk("cin_sequence", 32'(cins), 32'(exp_cins));
    if (glitch) chk("busy_cycles", 32'(nbusy), 32'd5);
  endtask

  initial begin
    int dones;
    #12;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_carry", 32'(carry_out), 32'd0);
    chk("reset_slice", 32'({slice_a, slice_b, slice_cin}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 4'b1110, 1'b1, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0, 1'b0);
    run_op(8'h37, 8'h12, 1'b0, 1'b0, 8'h49, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 4'b0000, 1'b0, 1'b1);

    // Abort in the second RUN cycle
    @(posedge clk); #1;
    op_a = 8'h12; op_b = 8'h34; cin_init = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    run_op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 4'b0000, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
    run_op(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 4'b0000, 1'b0, 1'b0);
    run_op(8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0, 4'b0000, 1'b0, 1'b0);
    sub = 1'b0;
`endif

    // Random traffic: start on any cycle, occasional asynchronous reset
    repeat (600) begin
      @(posedge clk); #1;
      rst      = 1'b0;
      start    = ($urandom_range(0, 2) == 0);
      op_a     = WIDTH'($urandom);
      op_b     = WIDTH'($urandom);
      cin_init = 1'($urandom_range(0, 1));
      if (SUB_EN) sub = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 79) == 0) begin
        #2 rst = 1'b1;
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
